// File: rtl/instr_fetch.sv
// instr_fetch: program-address generator for the synchronous ROM with a 2-entry queue feeding decode
module instr_fetch #(
    parameter int PC_WIDTH    = 4,
    parameter int INSTR_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic [PC_WIDTH-1:0]    mem_addr,
    output logic                   mem_en,
    input  logic [INSTR_WIDTH-1:0] mem_data,
    input  logic                   branch_en,
    input  logic [PC_WIDTH-1:0]    branch_target,
    output logic [INSTR_WIDTH-1:0] instr_out,
    output logic [PC_WIDTH-1:0]    instr_pc,
    output logic                   instr_valid,
    input  logic                   instr_ready
);
    logic [PC_WIDTH-1:0]    fetch_pc;
    logic [PC_WIDTH-1:0]    inflight_pc;
    logic                   inflight;
    logic [PC_WIDTH-1:0]    q_pc [2];
    logic [INSTR_WIDTH-1:0] q_instr [2];
    logic                   head;
    logic [1:0]             count;
    logic                   pop;
    logic                   push;
    logic                   issue;
    logic                   tail;

    // handshake, credit check and redirect mux; outputs read as zero while reset is held
    always_comb begin
        instr_valid = reset && (count != 2'd0) && !branch_en;
        pop         = instr_valid && instr_ready;
        push        = inflight && !branch_en;
        issue       = ({1'b0, count} + {2'b0, inflight}) < (3'd2 + {2'b0, pop});
        tail        = head ^ count[0];
        mem_en      = reset && (branch_en || issue);
        mem_addr    = branch_en ? branch_target : fetch_pc;
        instr_out   = (reset && count != 2'd0) ? q_instr[head] : '0;
        instr_pc    = (reset && count != 2'd0) ? q_pc[head] : '0;
    end

    // fetch address and the single outstanding ROM read
    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_pc    <= '0;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else if (branch_en) begin
            fetch_pc    <= branch_target + PC_WIDTH'(1);
            inflight    <= 1'b1;
            inflight_pc <= branch_target;
        end else begin
            inflight <= issue;
            if (issue) begin
                fetch_pc    <= fetch_pc + PC_WIDTH'(1);
                inflight_pc <= fetch_pc;
            end
        end
    end

    // queue occupancy: head advances on pop, a redirect flushes everything
    always_ff @(posedge clk) begin
        if (!reset || branch_en) begin
            count <= 2'd0;
            head  <= 1'b0;
        end else begin
            count <= count + {1'b0, push} - {1'b0, pop};
            head  <= head ^ pop;
        end
    end

    // queue storage: the returning word lands at the tail slot, which may be the slot being popped
    always_ff @(posedge clk) begin
        if (push) begin
            q_pc[tail]    <= inflight_pc;
            q_instr[tail] <= mem_data;
        end
    end

    // the credit rule must keep a return from landing in a full queue
    always_ff @(posedge clk) begin
        if (reset && push && !pop)
            assert (count != 2'd2);
    end
endmodule
